// File: rtl/instr_encode_loader_if.sv
// rtl/instr_encode_loader_if.sv - field-bundle stream in, instruction-memory write port out
interface instr_encode_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_ri;
  logic [5:0]        in_rs;
  logic [5:0]        in_rd;
  logic              in_mode;
  logic [2:0]        in_fcode;
  logic [5:0]        in_rt;
  logic [14:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  in_valid, in_ri, in_rs, in_rd, in_mode, in_fcode, in_rt, in_imm, in_last,
    output in_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );

  modport master (
    output in_valid, in_ri, in_rs, in_rd, in_mode, in_fcode, in_rt, in_imm, in_last,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - packs field bundles into words and streams them into instruction memory
// Optional ENC_ILLEGAL_CHK_EN: drops I-type store bundles and pulses err.
module instr_encode_loader #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_encode_loader_if.slave  bus,
  output logic                  busy,
  output logic                  done,
`ifdef ENC_ILLEGAL_CHK_EN
  output logic                  err,
`endif
  output logic [ADDR_W:0]       count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]       PTR_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       enc_word;
  logic              full, empty, accept, illegal, push, pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign accept = bus.in_valid && bus.in_ready;
`ifdef ENC_ILLEGAL_CHK_EN
  assign illegal = bus.in_ri && (bus.in_fcode == 3'b110) && !bus.in_mode;
`else
  assign illegal = 1'b0;
`endif
  assign push = accept && !illegal;
  assign pop  = bus.mem_we && bus.mem_ready;

  assign bus.mem_wdata = fifo_mem[rd_ptr[PW-1:0]];
  assign bus.mem_addr  = wr_addr;

  always_comb begin
    enc_word        = '0;
    enc_word[31]    = bus.in_ri;
    enc_word[30:25] = bus.in_rs;
    enc_word[24:19] = bus.in_rd;
    enc_word[18]    = bus.in_mode;
    enc_word[17:15] = bus.in_fcode;
    if (bus.in_ri) begin
      enc_word[14:0] = bus.in_imm;
    end else begin
      enc_word[14:9] = bus.in_rt;
    end
  end

  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        bus.in_ready = !full;
        bus.mem_we   = !empty;
        busy         = 1'b1;
        if (bus.in_valid && !full && bus.in_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        bus.mem_we = !empty;
        busy       = 1'b1;
        if (empty) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_addr <= BASE;
      count   <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (state == S_IDLE && start) begin
        wr_addr <= BASE;
        count   <= '0;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        wr_addr <= wr_addr + ADDR_ONE;
        count   <= count + CNT_ONE;
      end
    end
  end

  // Payload storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= enc_word;
  end

`ifdef ENC_ILLEGAL_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= accept && illegal;
    end
  end
`endif
endmodule
